// File: rtl/grid_square_plotter.sv
// Walks a COLS x ROWS grid of SQ_SIZE x SQ_SIZE squares and emits one pixel per clock.
// The pattern, active, beat and clear inputs are captured once per pass so the image never tears.
module grid_square_plotter #(
    parameter int COLS    = 8,
    parameter int ROWS    = 4,
    parameter int SQ_SIZE = 4,
    parameter int X0      = 10,
    parameter int Y0      = 20,
    parameter int X_PITCH = 20,
    parameter int Y_PITCH = 20,
    parameter int XW      = 8,
    parameter int YW      = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    clear,
    input  logic [COLS*ROWS-1:0]    pattern,
    input  logic [ROWS-1:0]         active,
    input  logic [$clog2(COLS)-1:0] beat,
    output logic [XW-1:0]           x,
    output logic [YW-1:0]           y,
    output logic [2:0]              colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    localparam int CW  = $clog2(COLS);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int NPX = SQ_SIZE * SQ_SIZE;
    localparam int PW  = (NPX > 1) ? $clog2(NPX) : 1;
    localparam int IW  = $clog2(COLS * ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          col, col_nx;
    logic [RW-1:0]          row, row_nx;
    logic [PW-1:0]          px, px_nx;
    logic [COLS*ROWS-1:0]   pat_s, pat_nx;
    logic [ROWS-1:0]        act_s, act_nx;
    logic [CW-1:0]          beat_s, beat_nx;
    logic                   clr_s, clr_nx;
    logic [IW-1:0]          cell_nx;
    logic                   last, load, emit;

    function automatic logic [XW-1:0] pix_x(input logic [CW-1:0] c, input logic [PW-1:0] p);
        return XW'(32'(X0) + 32'(c) * 32'(X_PITCH) + 32'(p) % 32'(SQ_SIZE));
    endfunction

    function automatic logic [YW-1:0] pix_y(input logic [RW-1:0] r, input logic [PW-1:0] p);
        return YW'(32'(Y0) + 32'(r) * 32'(Y_PITCH) + 32'(p) / 32'(SQ_SIZE));
    endfunction

    // First matching rule wins; the playhead column overrides the note/enable colouring.
    function automatic logic [2:0] cell_colour(input logic clr, input logic hit,
                                               input logic p, input logic a);
        if (clr)     return 3'b000;
        if (hit)     return p ? 3'b110 : 3'b001;
        if (p && a)  return 3'b010;
        if (p)       return 3'b100;
        return 3'b111;
    endfunction

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        px_nx    = px;
        pat_nx   = pat_s;
        act_nx   = act_s;
        beat_nx  = beat_s;
        clr_nx   = clr_s;
        load     = 1'b0;
        emit     = 1'b0;
        last     = (col == CW'(COLS - 1)) && (row == RW'(ROWS - 1)) && (px == PW'(NPX - 1));

        case (state)
            IDLE: load = start;
            DRAW: begin
                if (last) begin
                    state_nx = DONE;
                end else begin
                    emit = 1'b1;
                    if (px == PW'(NPX - 1)) begin
                        px_nx = '0;
                        if (row == RW'(ROWS - 1)) begin
                            row_nx = '0;
                            col_nx = col + CW'(1);
                        end else begin
                            row_nx = row + RW'(1);
                        end
                    end else begin
                        px_nx = px + PW'(1);
                    end
                end
            end
            DONE: begin
                load     = continuous;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Accepting a pass emits pixel 0 from the live inputs on the same edge.
        if (load) begin
            state_nx = DRAW;
            emit     = 1'b1;
            col_nx   = '0;
            row_nx   = '0;
            px_nx    = '0;
            pat_nx   = pattern;
            act_nx   = active;
            beat_nx  = beat;
            clr_nx   = clear;
        end

        cell_nx = IW'(32'(col_nx) * 32'(ROWS) + 32'(row_nx));
    end

    // ---- registered pixel stage ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            px     <= '0;
            pat_s  <= '0;
            act_s  <= '0;
            beat_s <= '0;
            clr_s  <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= 3'b000;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            col    <= col_nx;
            row    <= row_nx;
            px     <= px_nx;
            pat_s  <= pat_nx;
            act_s  <= act_nx;
            beat_s <= beat_nx;
            clr_s  <= clr_nx;
            plot   <= emit;
            busy   <= emit;
            done   <= (state == DRAW) && last;
            if (emit) begin
                x      <= pix_x(col_nx, px_nx);
                y      <= pix_y(row_nx, px_nx);
                colour <= cell_colour(clr_nx, beat_nx == col_nx, pat_nx[cell_nx], act_nx[row_nx]);
            end
        end
    end

endmodule

// File: tb/tb_grid_square_plotter.sv
// Scoreboard bench for grid_square_plotter: default build plus a 16x2 alternate build.
module tb_grid_square_plotter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, continuous = 1'b0, clear = 1'b0;
    logic [31:0] pattern = '0;
    logic [3:0]  active = '0;
    logic [2:0]  beat = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    logic        start2 = 1'b0;
    logic [31:0] pattern2 = '0;
    logic [1:0]  active2 = '0;
    logic [3:0]  beat2 = '0;
    logic [7:0]  x2;
    logic [6:0]  y2;
    logic [2:0]  colour2;
    logic        plot2, busy2, done2;

    always #5 clk = ~clk;

    grid_square_plotter dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .clear(clear),
        .pattern(pattern), .active(active), .beat(beat),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    grid_square_plotter #(
        .COLS(16), .ROWS(2), .SQ_SIZE(2), .X0(0), .Y0(0), .X_PITCH(10), .Y_PITCH(10),
        .XW(8), .YW(7)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .continuous(1'b0), .clear(1'b0),
        .pattern(pattern2), .active(active2), .beat(beat2),
        .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2), .done(done2)
    );

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         pix_idx = 0;
    logic [7:0] cap_x[512];
    logic [6:0] cap_y[512];
    logic [2:0] cap_c[512];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic logic [2:0] model_colour(input logic [31:0] pat, input logic [3:0] act,
                                                input int bt, input bit clr, input int c, input int r);
        logic p, a;
        p = pat[c*4 + r];
        a = act[r];
        if (clr)          return 3'b000;
        else if (c == bt) return p ? 3'b110 : 3'b001;
        else if (p && a)  return 3'b010;
        else if (p)       return 3'b100;
        else              return 3'b111;
    endfunction

    task automatic push_pass(input logic [31:0] pat, input logic [3:0] act, input int bt,
                             input bit clr, input int limit);
        int n;
        pix_t e;
        n = 0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                for (int dy = 0; dy < 4; dy++)
                    for (int dx = 0; dx < 4; dx++) begin
                        if (n < limit) begin
                            e.px = 8'(10 + 20*c + dx);
                            e.py = 7'(20 + 20*r + dy);
                            e.pc = model_colour(pat, act, bt, clr, c, r);
                            exp_q.push_back(e);
                        end
                        n++;
                    end
    endtask

    task automatic start_pass(input logic [31:0] pat, input logic [3:0] act, input logic [2:0] bt,
                              input logic clr, input logic cont);
        @(negedge clk);
        pattern = pat; active = act; beat = bt; clear = clr; continuous = cont;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int cyc_in, output int cyc_out);
        int c;
        c = cyc_in;
        while (!done && c < 2000) begin
            @(negedge clk);
            c++;
        end
        cyc_out = c;
    endtask

    always @(negedge clk) begin
        if (plot) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d, expected no plot", x, y, colour);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                if ({x, y, colour} !== e) begin
                    n_bad++;
                    $display("FAIL pixel[%0d]: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                             pix_idx, x, y, colour, e.px, e.py, e.pc);
                end
            end
            if (pix_idx < 512) begin
                cap_x[pix_idx] = x;
                cap_y[pix_idx] = y;
                cap_c[pix_idx] = colour;
            end
            pix_idx++;
        end else begin
            pix_idx = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, cnt, lx, ly, to;

        repeat (3) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic pass: blank pattern, playhead on column 0.
        push_pass(32'h0, 4'h0, 0, 1'b0, 512);
        start_pass(32'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk("first_plot", plot, 1);
        chk("first_busy", busy, 1);
        wait_done(1, cyc);
        chk("pass_len", cyc, 513);
        chk("done_busy", busy, 0);
        chk("done_plot", plot, 0);
        @(negedge clk);
        chk("done_pulse_1cyc", done, 0);
        chk("idle_plot", plot, 0);
        chk("hold_x", x, 153);
        chk("hold_y", y, 83);
        chk("p0_x", cap_x[0], 10);
        chk("p0_y", cap_y[0], 20);
        chk("p0_c", cap_c[0], 3'b001);
        chk("p4_y", cap_y[4], 21);
        chk("p16_y", cap_y[16], 40);
        chk("p64_x", cap_x[64], 30);
        chk("p511_x", cap_x[511], 153);
        chk("p511_y", cap_y[511], 83);
        chk("q_empty_a", exp_q.size(), 0);

        // Colour rules on cell (col1,row1) and playhead column 3.
        push_pass(32'h20, 4'b0010, 3, 1'b0, 512);
        start_pass(32'h20, 4'b0010, 3'd3, 1'b0, 1'b0);
        wait_done(1, cyc);
        chk("green_cell", cap_c[80], 3'b010);
        chk("beat_blank", cap_c[192], 3'b001);
        chk("white_cell", cap_c[0], 3'b111);

        push_pass(32'h20, 4'b0000, 3, 1'b0, 512);
        start_pass(32'h20, 4'b0000, 3'd3, 1'b0, 1'b0);
        wait_done(1, cyc);
        chk("red_cell", cap_c[80], 3'b100);

        push_pass(32'h20, 4'b0010, 1, 1'b0, 512);
        start_pass(32'h20, 4'b0010, 3'd1, 1'b0, 1'b0);
        wait_done(1, cyc);
        chk("yellow_cell", cap_c[80], 3'b110);
        chk("q_empty_b", exp_q.size(), 0);

        // Inputs changed and start re-pulsed mid-pass must not disturb the pass.
        push_pass(32'hA5A5_0F0F, 4'b1001, 2, 1'b0, 512);
        start_pass(32'hA5A5_0F0F, 4'b1001, 3'd2, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        pattern = 32'hFFFF_FFFF; active = 4'hF; beat = 3'd6; clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(102, cyc);
        chk("midpass_len", cyc, 513);
        @(negedge clk);
        chk("midpass_no_restart", plot, 0);
        chk("q_empty_c", exp_q.size(), 0);

        // Continuous refresh: one-cycle gap between passes.
        push_pass(32'h0000_FF00, 4'b0101, 5, 1'b0, 512);
        push_pass(32'h0000_FF00, 4'b0101, 5, 1'b0, 512);
        start_pass(32'h0000_FF00, 4'b0101, 3'd5, 1'b0, 1'b1);
        wait_done(1, cyc);
        chk("cont_len1", cyc, 513);
        @(negedge clk);
        chk("cont_plot", plot, 1);
        chk("cont_x", x, 10);
        chk("cont_y", y, 20);
        continuous = 1'b0;
        wait_done(1, cyc);
        chk("cont_len2", cyc, 513);
        @(negedge clk);
        chk("cont_stop", plot, 0);
        chk("q_empty_d", exp_q.size(), 0);

        // Clear paints everything black regardless of pattern.
        push_pass(32'hFFFF_FFFF, 4'hF, 0, 1'b1, 512);
        start_pass(32'hFFFF_FFFF, 4'hF, 3'd0, 1'b1, 1'b0);
        wait_done(1, cyc);
        chk("clear_p0", cap_c[0], 0);
        chk("clear_p511", cap_c[511], 0);
        clear = 1'b1;
        @(negedge clk);
        chk("clear_alone_idle", plot, 0);
        clear = 1'b0;

        // Reset aborts a pass after pixel 300.
        push_pass(32'h1234_5678, 4'b0110, 4, 1'b0, 301);
        start_pass(32'h1234_5678, 4'b0110, 3'd4, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_x", x, 0);
        chk("abort_y", y, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("q_empty_e", exp_q.size(), 0);
        push_pass(32'h0, 4'h0, 7, 1'b0, 512);
        start_pass(32'h0, 4'h0, 3'd7, 1'b0, 1'b0);
        chk("restart_x", x, 10);
        chk("restart_y", y, 20);
        wait_done(1, cyc);
        chk("restart_len", cyc, 513);
        @(negedge clk);

        // Alternate geometry build.
        cnt = 0; lx = 0; ly = 0; to = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while (!done2 && to < 1000) begin
            if (plot2) begin
                cnt++;
                lx = x2;
                ly = y2;
            end
            @(negedge clk);
            to++;
        end
        chk("alt_done", done2, 1);
        chk("alt_len", cnt, 128);
        chk("alt_last_x", lx, 151);
        chk("alt_last_y", ly, 11);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
